// File: rtl/cordic_rotator_if.sv
// Handshake and operand bundle for cordic_rotator: input operands with valid/ready,
// rotated result with valid/ready.
interface cordic_rotator_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 20
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [WIDTH-1:0]  xi;
    logic signed [WIDTH-1:0]  yi;
    logic        [AWIDTH-1:0] zi;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [WIDTH+1:0]  xo;
    logic signed [WIDTH+1:0]  yo;
    logic        [AWIDTH-1:0] zo;

    modport master (
        output in_valid, xi, yi, zi, out_ready,
        input  in_ready, out_valid, xo, yo, zo
    );

    modport slave (
        input  in_valid, xi, yi, zi, out_ready,
        output in_ready, out_valid, xo, yo, zo
    );
endinterface

// File: rtl/cordic_rotator.sv
// Iterative rotation-mode CORDIC, one micro-rotation per enabled clock.
// Define CORDIC_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain K.
module cordic_rotator #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 20,
    parameter int ITER   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    cordic_rotator_if.slave  bus,
    output logic             busy
);
    localparam int XW = WIDTH + 2;
    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROT   = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
`ifdef CORDIC_GAIN_COMP_EN
    localparam logic [1:0] SCALE = 2'd3;
    localparam logic signed [16:0] GAIN_C = 17'sh09B75;
`endif

    // atan(2^-i) with 2^32 = 360 deg
    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  return 32'h20000000;  1:  return 32'h12E4051E;
            2:  return 32'h09FB385B;  3:  return 32'h051111D4;
            4:  return 32'h028B0D43;  5:  return 32'h0145D7E1;
            6:  return 32'h00A2F61E;  7:  return 32'h00517C55;
            8:  return 32'h0028BE53;  9:  return 32'h00145F2F;
            10: return 32'h000A2F98;  11: return 32'h000517CC;
            12: return 32'h00028BE6;  13: return 32'h000145F3;
            14: return 32'h0000A2FA;  15: return 32'h0000517D;
            16: return 32'h000028BE;  17: return 32'h0000145F;
            18: return 32'h00000A30;  19: return 32'h00000518;
            20: return 32'h0000028C;  21: return 32'h00000146;
            22: return 32'h000000A3;  23: return 32'h00000051;
            24: return 32'h00000029;  25: return 32'h00000014;
            26: return 32'h0000000A;  27: return 32'h00000005;
            28: return 32'h00000003;  29: return 32'h00000001;
            30: return 32'h00000001;
            default: return 32'h00000000;
        endcase
    endfunction

    // Keep the top AWIDTH bits, rounding half up
    function automatic logic [AWIDTH-1:0] atan_round(input int i);
        logic [32:0] c;
        c = {1'b0, atan32(i)};
        if (AWIDTH < 32)
            c = c + (33'd1 << (31 - AWIDTH));
        return AWIDTH'(c >> (32 - AWIDTH));
    endfunction

    logic [AWIDTH-1:0] atan_tab [ITER];

    generate
        for (genvar gi = 0; gi < ITER; gi++) begin : g_atan
            assign atan_tab[gi] = atan_round(gi);
        end
    endgenerate

    logic [1:0]               state_reg;
    logic [CW-1:0]            cnt_reg;
    logic signed [XW-1:0]     x_reg, y_reg;
    logic [AWIDTH-1:0]        z_reg;
    logic signed [XW-1:0]     xo_reg, yo_reg;
    logic [AWIDTH-1:0]        zo_reg;

    logic signed [XW-1:0]     x_ext, y_ext, x_pre, y_pre;
    logic [AWIDTH-1:0]        z_pre;
    logic signed [XW-1:0]     x_sh, y_sh, x_rot, y_rot;
    logic [AWIDTH-1:0]        z_rot, atan_cur;

    // Fold angles beyond +-90 deg into range by negating the vector (exact thanks to guard bits)
    always_comb begin
        x_ext = {{2{bus.xi[WIDTH-1]}}, bus.xi};
        y_ext = {{2{bus.yi[WIDTH-1]}}, bus.yi};
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = bus.zi;
        if (bus.zi[AWIDTH-1] != bus.zi[AWIDTH-2]) begin
            x_pre = -x_ext;
            y_pre = -y_ext;
            z_pre = bus.zi - {1'b1, {(AWIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        atan_cur = atan_tab[cnt_reg];
        x_sh     = x_reg >>> cnt_reg;
        y_sh     = y_reg >>> cnt_reg;
        if (!z_reg[AWIDTH-1]) begin
            x_rot = x_reg - y_sh;
            y_rot = y_reg + x_sh;
            z_rot = z_reg - atan_cur;
        end else begin
            x_rot = x_reg + y_sh;
            y_rot = y_reg - x_sh;
            z_rot = z_reg + atan_cur;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [XW+16:0] x_prod, y_prod;
    logic signed [XW-1:0]  x_scl, y_scl;

    always_comb begin
        x_prod = x_reg * GAIN_C;
        y_prod = y_reg * GAIN_C;
        x_scl  = XW'(x_prod >>> 16);
        y_scl  = XW'(y_prod >>> 16);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            xo_reg    <= '0;
            yo_reg    <= '0;
            zo_reg    <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_reg     <= x_pre;
                        y_reg     <= y_pre;
                        z_reg     <= z_pre;
                        cnt_reg   <= '0;
                        state_reg <= ROT;
                    end
                end
                ROT: begin
                    x_reg   <= x_rot;
                    y_reg   <= y_rot;
                    z_reg   <= z_rot;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                        state_reg <= SCALE;
`else
                        xo_reg    <= x_rot;
                        yo_reg    <= y_rot;
                        zo_reg    <= z_rot;
                        state_reg <= DONE;
`endif
                    end
                end
`ifdef CORDIC_GAIN_COMP_EN
                SCALE: begin
                    xo_reg    <= x_scl;
                    yo_reg    <= y_scl;
                    zo_reg    <= z_reg;
                    state_reg <= DONE;
                end
`endif
                DONE: begin
                    if (bus.out_ready)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign busy          = (state_reg != IDLE);
    assign bus.xo        = xo_reg;
    assign bus.yo        = yo_reg;
    assign bus.zo        = zo_reg;
endmodule

// File: doc/cordic_rotator.md
Name: cordic_rotator

Overview:
- Iterative rotation-mode CORDIC; the inverse direction of the vectoring pipe, which drives Y to zero and accumulates the angle.
- This block takes a vector (xi, yi) and an angle zi, drives the residual angle to zero, and outputs the rotated vector. Used as the sin/cos generator and the polar-to-rectangular converter.
- One micro-rotation per enabled clock, with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, signed input vector component width
- AWIDTH, 20, angle width; binary angle, 2^AWIDTH = 360 deg, two's complement
- ITER, 16, number of micro-rotations (1..AWIDTH-1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; when low, all state and outputs hold and no transfer occurs
- in_valid  in  1  input operands valid
- in_ready  out  1  block can accept; high only in IDLE
- xi  in  WIDTH  signed X
- yi  in  WIDTH  signed Y
- zi  in  AWIDTH  rotation angle
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- xo  out  WIDTH+2  signed rotated X
- yo  out  WIDTH+2  signed rotated Y
- zo  out  AWIDTH  residual angle, ideally near 0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; xo, yo, zo=0; out_valid=0; in_ready=1; busy=0; iteration counter=0. Reset mid-operation aborts the operation; the result is discarded.
- Input transfer happens on an edge where ena & in_valid & in_ready. Output transfer happens on an edge where ena & out_valid & out_ready.
- States:
  - IDLE: on input transfer, latch pre-rotated operands, set cnt=0, go to ROT.
  - ROT: perform micro-rotation cnt, then cnt++. After micro-rotation ITER-1, load xo/yo/zo, set out_valid=1, go to DONE. (With the macro, go to SCALE instead; see Optional Feature.)
  - DONE: outputs held stable. On output transfer, clear out_valid and return to IDLE.
- Latency: out_valid is first high after exactly ITER enabled edges following the acceptance edge. Each ena-low cycle stretches latency by exactly one cycle. Throughput is one result per ITER+2 cycles minimum.
- Pre-rotation at acceptance: sign-extend xi/yi to WIDTH+2.
  - If zi[AWIDTH-1] != zi[AWIDTH-2] (|angle| > 90 deg): X=-x, Y=-y, Z=zi - 2^(AWIDTH-1), mod 2^AWIDTH.
  - Otherwise pass through unchanged.
  - Negating the most negative input is exact because of the 2 guard bits.
- Micro-rotation i, with >>> meaning arithmetic shift:
  - If Z >= 0 (sign bit 0): X' = X - (Y>>>i); Y' = Y + (X>>>i); Z' = Z - atan_i.
  - Otherwise: X' = X + (Y>>>i); Y' = Y - (X>>>i); Z' = Z + atan_i.
- X/Y arithmetic is WIDTH+2 wide, two's complement, no saturation. The guard bits cover gain K=1.64676 times sqrt(2).
- atan_i = round(atan(2^-i) * 2^AWIDTH / 360 deg). Generated from a 32-bit constant table by taking the top AWIDTH bits with round-half-up; entries for i >= 31 are 0.
  - 32-bit constants: i0=0x20000000, i1=0x12E4051E, i2=0x09FB385B, i3=0x051111D4, i4=0x028B0D43.
  - For AWIDTH=20: i0=0x20000, i1=0x12E40, i2=0x09FB4.
- Output gain: without the macro, output magnitude = K * |input| (K about 1.64676).
- Input transfer while busy is impossible, since in_ready=0. In_valid held through DONE is not accepted until IDLE.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined: extra state SCALE follows the final ROT.
  - xo = (X * 0x9B75) >>> 16 and yo likewise; 0x9B75 = round(0.607253 * 2^16). Product is truncated toward -inf.
  - zo = Z.
  - out_valid then rises after ITER+1 enabled edges.
- Undefined: no SCALE state, no multiplier; outputs carry gain K.

Test Plan:
1. WIDTH=16, AWIDTH=20, ITER=16; xi=16384, yi=0, zi=0 -> xo=26981±4, yo=0±4, |zo|<=2, out_valid after 16 edges. With macro: xo=16384±4, latency 17.
2. xi=16384, yi=0, zi=0x40000 (90 deg) -> xo=0±4, yo=26981±4.
3. xi=16384, yi=0, zi=0x80000 (180 deg, pre-rotation path) -> xo=-26981±4, yo=0±4. Also xi=-32768, yi=-32768, zi=0 -> xo=yo=-53962±8, no overflow.
4. xi=16384, yi=0, zi=0xE0000 (-45 deg) -> xo=19079±4, yo=-19079±4.
5. Backpressure and enable:
   - out_ready=0 for 10 cycles -> outputs stable, in_ready=0, busy=1; one cycle after out_ready=1, out_valid=0 and in_ready=1.
   - ena low 3 cycles mid-ROT -> latency exactly ITER+3.
6. rst_n low during ROT at cnt=5 -> immediately out_valid=0, xo=yo=zo=0, busy=0, in_ready=1. The next operation after release produces correct case-1 results.
